// File: rtl/probe_snapshot_reader_pkg.sv
// probe_snapshot_reader_pkg: selector encoding and reader states shared by the probe and its reader
package probe_snapshot_reader_pkg;
  localparam logic [3:0] SEL_CNT_B0 = 4'h8;
  localparam logic [3:0] SEL_CNT_B1 = 4'h9;
  localparam logic [3:0] SEL_CNT_B2 = 4'hA;
  localparam logic [3:0] SEL_CNT_B3 = 4'hB;
  localparam logic [3:0] SEL_PC_B0  = 4'h0;
  localparam logic [3:0] SEL_PC_B1  = 4'h1;
  localparam logic [3:0] SEL_PC_B2  = 4'h2;
  localparam logic [3:0] SEL_PC_B3  = 4'h3;
  typedef enum logic [1:0] {IDLE, READ, CHECK, HOLD} state_e;
  // Byte index 0..3 walks the count bytes, 4..7 the pc bytes; bit2 of the code is always 0.
  function automatic logic [3:0] sel_of(input logic [2:0] idx);
    return {~idx[2], 1'b0, idx[1:0]};
  endfunction
endpackage

// File: rtl/probe_snapshot_reader_settle_timer.sv
// probe_snapshot_reader_settle_timer: loadable down-counter giving SETTLE cycles per probe sample
module probe_snapshot_reader_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  output logic zero_o
);
  localparam int W = $clog2(SETTLE + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // Reload to SETTLE-1 on request, otherwise count down and rest at zero.
  always_comb cnt_d = load_i ? W'(SETTLE - 1) : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  // Timer register.
  always_ff @(posedge clk) cnt_q <= !rstn ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/probe_snapshot_reader.sv
// probe_snapshot_reader: walks the probe selector, assembles count/pc and hands out a torn-checked snapshot
module probe_snapshot_reader
  import probe_snapshot_reader_pkg::*;
#(
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  output logic        busy_o,
  output logic [3:0]  sel_o,
  input  logic [7:0]  sgnl_i,
  output logic        snap_valid_o,
  input  logic        snap_ready_i,
  output logic [31:0] snap_count_o,
  output logic [31:0] snap_pc_o,
  output logic        snap_torn_o
);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] sel_q, sel_d, retry_q, retry_d;
  logic [31:0] cnt_q, cnt_d, pc_q, pc_d;
  logic torn_q, torn_d;
  logic tz, go, rd_step, ck_step, match, retry_ok;
  assign go       = state_q == IDLE && start_i;
  assign rd_step  = state_q == READ && tz;
  assign ck_step  = state_q == CHECK && tz;
  assign match    = sgnl_i == cnt_q[7:0];
  assign retry_ok = retry_q < RETRY_MAX;
  probe_snapshot_reader_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (go || rd_step || ck_step),
    .zero_o (tz)
  );
  // State register.
  always_ff @(posedge clk) state_q <= !rstn ? IDLE : state_d;
  // Next state: eight byte reads, one re-read of count byte 0, then hold until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? READ : IDLE;
      READ:    state_d = (tz && idx_q == 3'd7) ? CHECK : READ;
      CHECK:   state_d = !tz ? CHECK : (match || !retry_ok) ? HOLD : READ;
      HOLD:    state_d = snap_ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // Outputs decoded from state; data comes straight from the capture registers.
  always_comb begin
    busy_o       = state_q != IDLE;
    snap_valid_o = state_q == HOLD;
    sel_o        = sel_q;
    snap_count_o = cnt_q;
    snap_pc_o    = pc_q;
    snap_torn_o  = torn_q;
  end
  // Datapath next state: selector walk, byte capture, retry count and torn flag.
  always_comb begin
    idx_d   = go ? 3'd0 : rd_step ? idx_q + 3'd1 : idx_q;
    sel_d   = go ? SEL_CNT_B0 : rd_step ? sel_of(idx_q + 3'd1) : sel_q;
    retry_d = go ? 4'd0 : (ck_step && !match && retry_ok) ? retry_q + 4'd1 : retry_q;
    torn_d  = (ck_step && (match || !retry_ok)) ? !match : torn_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    if (rd_step && !idx_q[2]) cnt_d[{idx_q[1:0], 3'b000} +: 8] = sgnl_i;
    if (rd_step && idx_q[2]) pc_d[{idx_q[1:0], 3'b000} +: 8] = sgnl_i;
  end
  // Datapath registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q   <= '0;
      sel_q   <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      torn_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      torn_q  <= torn_d;
    end
  end
endmodule

// File: tb/tb_probe_snapshot_reader.sv
// tb_probe_snapshot_reader: directed scoreboard bench with a registered byte-probe model
module tb_probe_snapshot_reader;
  typedef struct {
    logic [31:0] c;
    logic        cc;
    logic [31:0] p;
    logic        t;
    int          lat;
  } exp_t;
  logic clk = 0, rstn = 0, start = 0, snap_ready = 0;
  logic start3 = 0, ready3 = 0;
  logic busy, snap_valid, snap_torn, busy3, valid3, torn3;
  logic [3:0] sel, sel3;
  logic [7:0] sgnl = 0, sgnl3 = 0;
  logic [31:0] snap_count, snap_pc, count3, pc3;
  logic [31:0] cnt_m = 0, pc_m = 0;
  logic [3:0] seq [9] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3, 4'h8};
  exp_t sbq[$];
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  probe_snapshot_reader dut (
    .clk(clk), .rstn(rstn), .start_i(start), .busy_o(busy), .sel_o(sel), .sgnl_i(sgnl),
    .snap_valid_o(snap_valid), .snap_ready_i(snap_ready), .snap_count_o(snap_count),
    .snap_pc_o(snap_pc), .snap_torn_o(snap_torn)
  );
  probe_snapshot_reader #(.SETTLE(3)) dut3 (
    .clk(clk), .rstn(rstn), .start_i(start3), .busy_o(busy3), .sel_o(sel3), .sgnl_i(sgnl3),
    .snap_valid_o(valid3), .snap_ready_i(ready3), .snap_count_o(count3),
    .snap_pc_o(pc3), .snap_torn_o(torn3)
  );
  function automatic logic [7:0] pick(input logic [3:0] s, input logic [31:0] c, input logic [31:0] p);
    logic [31:0] src;
    src = s[3] ? c : p;
    return src[{s[1:0], 3'b000} +: 8];
  endfunction
  always @(posedge clk) begin
    sgnl  <= pick(sel, cnt_m, pc_m);
    sgnl3 <= pick(sel3, cnt_m, pc_m);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask
  task automatic run_snap(input logic [31:0] ec, input logic cc, input logic [31:0] ep,
                          input logic et, input int elat, input int mode);
    int cyc;
    exp_t e;
    e.c = ec; e.cc = cc; e.p = ep; e.t = et; e.lat = elat;
    sbq.push_back(e);
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    cyc = 0;
    while (!snap_valid && cyc < 200) begin
      chk("sel_seq", 32'(sel), 32'(seq[(cyc % 18) / 2]));
      if (mode == 1 && cyc == 11) cnt_m = cnt_m + 1;
      if (mode == 2) cnt_m = cnt_m + 1;
      @(posedge clk); #1 cyc++;
    end
    chk("snap_valid_seen", 32'(snap_valid), 1);
    if (sbq.size() == 0) chk("sb_nonempty", 0, 1);
    else begin
      e = sbq.pop_front();
      chk("latency", cyc, e.lat);
      if (e.cc) chk("snap_count", snap_count, e.c);
      chk("snap_pc", snap_pc, e.p);
      chk("snap_torn", 32'(snap_torn), 32'(e.t));
      chk("busy_hold", 32'(busy), 1);
    end
  endtask
  task automatic handshake(input logic st);
    @(negedge clk); snap_ready = 1; start = st;
    @(posedge clk); #1 snap_ready = 0; start = 0;
    chk("hs_valid", 32'(snap_valid), 0);
    chk("hs_busy", 32'(busy), 0);
    @(posedge clk); #1 chk("idle_busy", 32'(busy), 0);
  endtask
  initial begin
    int cyc;
    logic [31:0] hc;
    cnt_m = 32'h12345678; pc_m = 32'h0000ABCC;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(snap_valid), 0);
    chk("rst_count", snap_count, 0);
    chk("rst_pc", snap_pc, 0);
    chk("rst_torn", 32'(snap_torn), 0);
    @(negedge clk); rstn = 1;
    run_snap(32'h12345678, 1, 32'h0000ABCC, 0, 18, 0);
    handshake(0);
    cnt_m = 32'h12345678;
    run_snap(32'h12345679, 1, 32'h0000ABCC, 0, 36, 1);
    handshake(0);
    cnt_m = 32'h00000100;
    run_snap(32'h0, 0, 32'h0000ABCC, 1, 72, 2);
    handshake(0);
    cnt_m = 32'h12345678;
    run_snap(32'h12345678, 1, 32'h0000ABCC, 0, 18, 0);
    hc = snap_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start = ~start;
      @(posedge clk); #1;
      chk("hold_valid", 32'(snap_valid), 1);
      chk("hold_count", snap_count, hc);
      chk("hold_sel", 32'(sel), 32'h8);
    end
    start = 0;
    handshake(1);
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    cyc = 0;
    while (cyc < 11) begin
      @(posedge clk); #1 cyc++;
    end
    rstn = 0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_sel", 32'(sel), 0);
    chk("mid_rst_valid", 32'(snap_valid), 0);
    chk("mid_rst_count", snap_count, 0);
    chk("mid_rst_pc", snap_pc, 0);
    @(negedge clk); rstn = 1;
    run_snap(32'h12345678, 1, 32'h0000ABCC, 0, 18, 0);
    handshake(0);
    pc_m = 32'hDEAD0042;
    @(negedge clk); start3 = 1;
    @(posedge clk); #1 start3 = 0;
    cyc = 0;
    while (!valid3 && cyc < 200) begin
      chk("sel3_seq", 32'(sel3), 32'(seq[(cyc / 3 > 8) ? 8 : cyc / 3]));
      @(posedge clk); #1 cyc++;
    end
    chk("s3_latency", cyc, 27);
    chk("s3_count", count3, 32'h12345678);
    chk("s3_pc", pc3, 32'hDEAD0042);
    chk("s3_torn", 32'(torn3), 0);
    @(negedge clk); ready3 = 1;
    @(posedge clk); #1 ready3 = 0;
    chk("s3_idle", 32'(busy3), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/probe_snapshot_reader.md
Name: probe_snapshot_reader

Overview:
Consumer side of the instruction-counter/PC byte probe. On request, it steps the probe's 4-bit selector through all eight byte codes and samples the registered 8-bit probe output after the probe's latency. It assembles a 32-bit retired-instruction count and a 32-bit PC, and presents them as one snapshot on a valid/ready interface to the debug host logic (UART dumper / LED mux). A re-read check flags snapshots torn by the counter advancing mid-read.

Parameters:
SETTLE, 2, cycles from selector update to sgnl sample; legal range ≥2 (probe has 1 registered stage).
MAX_RETRY, 3, full re-read attempts after a torn read before delivering with snap_torn=1; legal range 0..15.

Ports:
clk  input  1  clock
rstn  input  1  synchronous, active-low reset
start  input  1  snapshot request; level-sampled, acted on only in IDLE
busy  output  1  high in every state except IDLE
sel  output  4  selector to probe; bit3=1 selects count, bit3=0 selects pc; bit2 always 0; bits[1:0] select byte (0=LSB)
sgnl  input  8  registered probe byte
snap_valid  output  1  snapshot available
snap_ready  input  1  consumer accept
snap_count  output  32  assembled instruction count
snap_pc  output  32  assembled PC
snap_torn  output  1  count advanced during read and retries exhausted

Behaviour:
- Reset, synchronous on rstn=0 (also mid-operation): state=IDLE; sel=4'h0; busy=0; snap_valid=0; snap_count=0; snap_pc=0; snap_torn=0; retry counter=0; settle timer=0.
- States: IDLE, READ, CHECK, HOLD.
- IDLE, start=1 at edge E0:
  - state→READ; byte index=0; sel=4'b1000; timer=SETTLE-1; retry counter=0; busy=1 from E0.
- READ:
  - Sequence of sel codes: 1000, 1001, 1010, 1011 (count bytes 0..3), then 0000, 0001, 0010, 0011 (pc bytes 0..3).
  - While timer≠0, decrement.
  - At the edge where timer==0: capture sgnl into the byte slot for the current sel, load the next sel, and reset timer=SETTLE-1. Each byte therefore occupies exactly SETTLE cycles.
  - After the pc byte 3 capture: sel=4'b1000, state→CHECK.
- CHECK:
  - After SETTLE cycles, compare sgnl with captured count[7:0].
  - Equal → snap_torn=0, state→HOLD.
  - Unequal and retry counter<MAX_RETRY → increment retry counter, restart READ at count byte 0 with sel=1000. Previously captured bytes are overwritten.
  - Unequal and retries exhausted → snap_torn=1, state→HOLD.
- HOLD:
  - snap_valid=1. snap_count, snap_pc and snap_torn are stable until handshake.
  - On the edge with snap_valid&snap_ready: snap_valid→0, state→IDLE, busy→0. Data registers retain their last values.
- start while not IDLE is ignored (not queued). In IDLE, start=1 on the same edge HOLD exits is not seen; a new snapshot begins at the earliest 1 cycle after return to IDLE.
- Latency, clean read: start edge to snap_valid=1 is 9×SETTLE cycles (18 at default). Each retry adds 9×SETTLE.
- sel stays at its last driven value in IDLE and HOLD. The probe's sgnl is don't-care outside READ/CHECK.
- Byte assembly: slot k of count/pc = bits[8k+7:8k]. No arithmetic is performed on the data.

Decomposition:
- Shared debug package: sel code constants (SEL_CNT_B0..B3 = 4'h8..4'hB, SEL_PC_B0..B3 = 4'h0..4'h3) and the state enum, so the probe and the reader agree on the encoding.
- Optional sub-module settle_timer: load/decrement/zero flag, parameterised by SETTLE. The remaining logic stays in one module.

Test Plan:
- Probe model, count=32'h12345678, pc=32'h0000ABCC, static; start pulse → sel sequence 8,9,A,B,0,1,2,3,8 at SETTLE spacing; snap_valid at cycle 18; count=12345678, pc=0000ABCC, torn=0.
- Count increments once during pc byte 1 (…78→…79) → CHECK mismatch, one retry; snapshot count=12345679, torn=0, snap_valid at cycle 36.
- Count increments every cycle, MAX_RETRY=3 → 4 reads, then snap_valid at cycle 72 with snap_torn=1.
- HOLD with snap_ready=0 for 10 cycles, start toggled → outputs stable, no new read; snap_ready=1 → IDLE next cycle, busy=0.
- rstn=0 during READ byte 5 → next cycle: all outputs 0, state IDLE; subsequent start yields a full clean snapshot.
- SETTLE=3 → each sel held 3 cycles; snap_valid at cycle 27.
